id_operand_issue: RTL and testbench
===================================

ID_OPERAND_ISSUE -- requirements
Module: id_operand_issue

Parameters
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter NREAD, default 2, number of source operand read ports.
REQ-003 SHALL have parameter NFWD, default 2, number of forwarding sources; index 0 is the highest priority (youngest).
REQ-004 SHALL have parameter PW, default 64, width of the pass-through decoded payload.
REQ-005 SHALL have parameter MAXPEND, default 3, maximum in-flight writes tracked per register; CW = clog2(MAXPEND+1).

Interface
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have ports fs_to_ds_valid (in, 1), ds_allowin (out, 1): upstream handshake.
REQ-009 SHALL have port fs_payload, in, PW: decoded payload, captured opaquely.
REQ-010 SHALL have ports fs_raddr (in, NREAD*5), fs_ruse (in, NREAD), fs_dest (in, 5), fs_gr_we (in, 1): operand and destination descriptors.
REQ-011 SHALL have ports ds_to_es_valid (out, 1), es_allowin (in, 1), ds_payload (out, PW), ds_src_value (out, NREAD*XLEN): downstream handshake and data.
REQ-012 SHALL have ports rf_raddr (out, NREAD*5), rf_rdata (in, NREAD*XLEN): combinational register-file read.
REQ-013 SHALL have ports fwd_valid (in, NFWD), fwd_ready (in, NFWD), fwd_addr (in, NFWD*5), fwd_data (in, NFWD*XLEN); fwd_ready=0 marks a result not yet produced (load in EXE).
REQ-014 SHALL have ports wb_valid (in, 1), wb_addr (in, 5): register-file write commit.
REQ-015 SHALL have port flush (in, 1): discard the held instruction (branch redirect).
REQ-016 SHALL have port ds_stall (out, 1): held valid instruction cannot issue this cycle.

Function
REQ-017 SHALL hold one instruction in a stage register (ds_valid plus captured inputs), loaded when fs_to_ds_valid && ds_allowin.
REQ-018 SHALL drive ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go && !flush.
REQ-019 SHALL clear ds_valid on the cycle after flush=1 and SHALL NOT capture new input in a flush cycle.
REQ-020 SHALL keep a per-register pending counter pend[1..31] of width CW; r0 is never pending.
REQ-021 SHALL increment pend[fs_dest] on issue (ds_to_es_valid && es_allowin && gr_we && dest!=0); decrement pend[wb_addr] on wb_valid with wb_addr!=0.
REQ-022 SHALL leave a counter unchanged when increment and decrement hit the same register in one cycle.
REQ-023 SHALL treat decrement of a zero counter as no-op; increment of a counter at MAXPEND shall never occur (see REQ-026).
REQ-024 SHALL resolve each used source i: addr 0 -> 0; else the lowest-index fwd j with fwd_valid&&addr match -> fwd_data[j]; else rf_rdata[i].
REQ-025 SHALL mark source i blocked when used, addr!=0, pend[addr]!=0, and either no forwarding match or the highest-priority match has fwd_ready=0.
REQ-026 SHALL deassert ds_ready_go when any source is blocked or when gr_we, dest!=0 and pend[dest]==MAXPEND.
REQ-027 SHALL drive ds_stall = ds_valid && !ds_ready_go; unused sources (fs_ruse=0) never block and output 0.
REQ-028 SHALL produce ds_src_value combinationally in the issue cycle (zero added latency from forward to issue).

Reset
REQ-029 SHALL on reset clear ds_valid and all pend counters; ds_to_es_valid=0, ds_stall=0, ds_allowin=1 in the following cycle.
REQ-030 SHALL on reset mid-operation discard the held instruction and all in-flight tracking; later wb_valid for those registers shall be no-ops by REQ-023.

Verification
REQ-031 SHALL test back-to-back: issue dest r5=write, next reads r5 with fwd[0] valid/ready addr5 data 0x1234 -> issues in 1 cycle, ds_src_value=0x1234.
REQ-032 SHALL test load-use: pend[r7]=1, fwd[0] addr7 ready=0 -> ds_stall=1 one cycle; next cycle fwd[1] ready data 0xBEEF -> issues with 0xBEEF.
REQ-033 SHALL test priority: fwd[0] and fwd[1] both addr 3 with 0xA/0xB -> value 0xA.
REQ-034 SHALL test saturation: MAXPEND=3 writes to r9 outstanding, fourth writer stalls until wb_valid addr 9, then issues; pend[9] stays 3.
REQ-035 SHALL test flush while stalled on es_allowin=0 -> ds_valid=0 next cycle, pend unchanged; reading r0 yields 0 with no stall.

Source files
------------

// File: rtl/id_operand_issue.sv
// Decode-stage operand issue: holds one decoded instruction, resolves its source
// operands from forwarding paths or the register file, and tracks in-flight writes per register.
module id_operand_issue #(
    parameter int XLEN    = 32,
    parameter int NREAD   = 2,
    parameter int NFWD    = 2,
    parameter int PW      = 64,
    parameter int MAXPEND = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fs_to_ds_valid,
    output logic                  ds_allowin,
    input  logic [PW-1:0]         fs_payload,
    input  logic [NREAD*5-1:0]    fs_raddr,
    input  logic [NREAD-1:0]      fs_ruse,
    input  logic [4:0]            fs_dest,
    input  logic                  fs_gr_we,
    output logic                  ds_to_es_valid,
    input  logic                  es_allowin,
    output logic [PW-1:0]         ds_payload,
    output logic [NREAD*XLEN-1:0] ds_src_value,
    output logic [NREAD*5-1:0]    rf_raddr,
    input  logic [NREAD*XLEN-1:0] rf_rdata,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_ready,
    input  logic [NFWD*5-1:0]     fwd_addr,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_addr,
    input  logic                  flush,
    output logic                  ds_stall
);

    localparam int CW = $clog2(MAXPEND + 1);

    logic                  ds_valid_q, ds_valid_d;
    logic [PW-1:0]         payload_q;
    logic [NREAD*5-1:0]    raddr_q;
    logic [NREAD-1:0]      ruse_q;
    logic [4:0]            dest_q;
    logic                  gr_we_q;
    logic [CW-1:0]         pend_q [32];
    logic [CW-1:0]         pend_d [32];

    logic                  ds_ready_go;
    logic                  load;
    logic                  inc;
    logic                  dec;
    logic [NREAD*XLEN-1:0] src_value;

    assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;
    assign ds_stall       = ds_valid_q && !ds_ready_go;
    assign load           = fs_to_ds_valid && ds_allowin && !flush;
    assign ds_payload     = payload_q;
    assign ds_src_value   = src_value;
    assign rf_raddr       = raddr_q;

    // Operand resolution: lowest-index forwarding match wins over the register file.
    always_comb begin
        logic [4:0]      a;
        logic            hit;
        logic            hit_rdy;
        logic [XLEN-1:0] hit_data;
        logic            blocked;
        a         = '0;
        hit       = 1'b0;
        hit_rdy   = 1'b0;
        hit_data  = '0;
        blocked   = 1'b0;
        src_value = '0;
        for (int i = 0; i < NREAD; i++) begin
            a        = raddr_q[i*5 +: 5];
            hit      = 1'b0;
            hit_rdy  = 1'b0;
            hit_data = '0;
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (fwd_addr[j*5 +: 5] == a)) begin
                    hit      = 1'b1;
                    hit_rdy  = fwd_ready[j];
                    hit_data = fwd_data[j*XLEN +: XLEN];
                end
            end
            if (ruse_q[i] && (a != 5'd0)) begin
                src_value[i*XLEN +: XLEN] = hit ? hit_data : rf_rdata[i*XLEN +: XLEN];
                if ((pend_q[a] != '0) && (!hit || !hit_rdy)) begin
                    blocked = 1'b1;
                end
            end
        end
        ds_ready_go = !blocked &&
                      !(gr_we_q && (dest_q != 5'd0) && (pend_q[dest_q] == CW'(MAXPEND)));
    end

    // Pending-write scoreboard; a simultaneous issue and commit to one register cancel out.
    always_comb begin
        inc    = ds_to_es_valid && es_allowin && gr_we_q && (dest_q != 5'd0);
        dec    = wb_valid && (wb_addr != 5'd0);
        pend_d = pend_q;
        if (inc && !(dec && (wb_addr == dest_q))) begin
            pend_d[dest_q] = pend_q[dest_q] + CW'(1);
        end
        if (dec && !(inc && (wb_addr == dest_q)) && (pend_q[wb_addr] != '0)) begin
            pend_d[wb_addr] = pend_q[wb_addr] - CW'(1);
        end
        pend_d[0] = '0;
    end

    always_comb begin
        ds_valid_d = ds_valid_q;
        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            ds_valid_q <= ds_valid_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            payload_q <= fs_payload;
            raddr_q   <= fs_raddr;
            ruse_q    <= fs_ruse;
            dest_q    <= fs_dest;
            gr_we_q   <= fs_gr_we;
        end
    end

endmodule

// File: tb/tb_id_operand_issue.sv
// Directed bench for id_operand_issue: forwarding, load-use stall, priority,
// pending saturation, flush and reset behaviour with hand-computed expectations.
module tb_id_operand_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_to_ds_valid;
    logic        ds_allowin;
    logic [63:0] fs_payload;
    logic [9:0]  fs_raddr;
    logic [1:0]  fs_ruse;
    logic [4:0]  fs_dest;
    logic        fs_gr_we;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [63:0] ds_payload;
    logic [63:0] ds_src_value;
    logic [9:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_ready;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        ds_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Register file model: register n reads as 0xA000_0000 | n.
    assign rf_rdata = {32'hA000_0000 | {27'b0, rf_raddr[9:5]},
                       32'hA000_0000 | {27'b0, rf_raddr[4:0]}};

    id_operand_issue dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .ds_allowin     (ds_allowin),
        .fs_payload     (fs_payload),
        .fs_raddr       (fs_raddr),
        .fs_ruse        (fs_ruse),
        .fs_dest        (fs_dest),
        .fs_gr_we       (fs_gr_we),
        .ds_to_es_valid (ds_to_es_valid),
        .es_allowin     (es_allowin),
        .ds_payload     (ds_payload),
        .ds_src_value   (ds_src_value),
        .rf_raddr       (rf_raddr),
        .rf_rdata       (rf_rdata),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .flush          (flush),
        .ds_stall       (ds_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_set(input int j, input logic v, input logic r,
                           input logic [4:0] a, input logic [31:0] d);
        fwd_valid[j]       = v;
        fwd_ready[j]       = r;
        fwd_addr[j*5 +: 5] = a;
        fwd_data[j*32 +: 32] = d;
    endtask

    task automatic fs_set(input logic v, input logic [4:0] dest, input logic we,
                          input logic [4:0] a0, input logic [4:0] a1,
                          input logic [1:0] ruse, input logic [63:0] pl);
        fs_to_ds_valid = v;
        fs_dest        = dest;
        fs_gr_we       = we;
        fs_raddr       = {a1, a0};
        fs_ruse        = ruse;
        fs_payload     = pl;
    endtask

    initial begin
        reset = 1'b1; es_allowin = 1'b1; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = 5'd0;
        fwd_valid = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
        fs_set(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 64'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", {63'b0, ds_to_es_valid}, 64'd0);
        chk("rst_stall", {63'b0, ds_stall}, 64'd0);
        chk("rst_allowin", {63'b0, ds_allowin}, 64'd1);

        // Back-to-back: writer of r5 then reader of r5 fed by fwd[0].
        fs_set(1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 2'b00, 64'h1111);
        tick();
        fs_set(1'b1, 5'd0, 1'b0, 5'd5, 5'd0, 2'b01, 64'h2222);
        #1;
        chk("b2b_w_valid", {63'b0, ds_to_es_valid}, 64'd1);
        chk("b2b_w_payload", ds_payload, 64'h1111);
        chk("b2b_w_allowin", {63'b0, ds_allowin}, 64'd1);
        tick();
        fs_to_ds_valid = 1'b0;
        fwd_set(0, 1'b1, 1'b1, 5'd5, 32'h1234);
        #1;
        chk("b2b_r_valid", {63'b0, ds_to_es_valid}, 64'd1);
        chk("b2b_r_stall", {63'b0, ds_stall}, 64'd0);
        chk("b2b_r_src", ds_src_value, 64'h0000_0000_0000_1234);
        tick();
        fwd_set(0, 1'b0, 1'b0, 5'd0, 32'h0);
        wb_valid = 1'b1; wb_addr = 5'd5;
        #1;
        chk("b2b_empty", {62'b0, ds_to_es_valid, ds_allowin}, 64'd1);
        tick();
        wb_valid = 1'b0;

        // Load-use on r7.
        fs_set(1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 2'b00, 64'h3333);
        tick();
        fs_set(1'b1, 5'd0, 1'b0, 5'd7, 5'd0, 2'b01, 64'h4444);
        tick();
        fs_to_ds_valid = 1'b0;
        fwd_set(0, 1'b1, 1'b0, 5'd7, 32'h5555);
        #1;
        chk("lu_stall", {63'b0, ds_stall}, 64'd1);
        chk("lu_valid", {63'b0, ds_to_es_valid}, 64'd0);
        chk("lu_allowin", {63'b0, ds_allowin}, 64'd0);
        tick();
        fwd_set(0, 1'b0, 1'b0, 5'd0, 32'h0);
        fwd_set(1, 1'b1, 1'b1, 5'd7, 32'hBEEF);
        #1;
        chk("lu_go_stall", {63'b0, ds_stall}, 64'd0);
        chk("lu_go_valid", {63'b0, ds_to_es_valid}, 64'd1);
        chk("lu_go_src", ds_src_value, 64'h0000_0000_0000_BEEF);
        tick();
        fwd_set(1, 1'b0, 1'b0, 5'd0, 32'h0);
        wb_valid = 1'b1; wb_addr = 5'd7;
        tick();
        wb_valid = 1'b0;

        // Forwarding priority and register-file fallback.
        fs_set(1'b1, 5'd0, 1'b0, 5'd3, 5'd4, 2'b11, 64'h6666);
        tick();
        fs_to_ds_valid = 1'b0;
        fwd_set(0, 1'b1, 1'b1, 5'd3, 32'hA);
        fwd_set(1, 1'b1, 1'b1, 5'd3, 32'hB);
        #1;
        chk("prio_src", ds_src_value, 64'hA000_0004_0000_000A);
        chk("prio_rfaddr", {54'b0, rf_raddr}, {54'b0, 5'd4, 5'd3});
        fwd_valid[0] = 1'b0;
        #1;
        chk("prio_fwd1", ds_src_value, 64'hA000_0004_0000_000B);
        tick();
        fwd_set(1, 1'b0, 1'b0, 5'd0, 32'h0);

        // Saturation: three writes to r9 outstanding, the fourth waits.
        fs_set(1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 64'h9000);
        tick(); tick(); tick(); tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("sat_stall", {63'b0, ds_stall}, 64'd1);
        chk("sat_valid", {63'b0, ds_to_es_valid}, 64'd0);
        tick();
        chk("sat_stall_hold", {63'b0, ds_stall}, 64'd1);
        wb_valid = 1'b1; wb_addr = 5'd9;
        #1;
        chk("sat_wb_cycle", {63'b0, ds_stall}, 64'd1);
        tick();
        wb_valid = 1'b0;
        fs_set(1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 64'h9005);
        #1;
        chk("sat_go_valid", {62'b0, ds_to_es_valid, ds_allowin}, 64'd3);
        chk("sat_go_payload", ds_payload, 64'h9000);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("sat_again_stall", {63'b0, ds_stall}, 64'd1);
        chk("sat_again_payload", ds_payload, 64'h9005);

        // Flush while blocked and downstream not accepting.
        es_allowin = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_valid", {63'b0, ds_to_es_valid}, 64'd0);
        tick();
        es_allowin = 1'b1;
        fs_set(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b01, 64'h7777);
        #1;
        chk("fl_cleared", {62'b0, ds_stall, ds_allowin}, 64'd1);
        tick();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        chk("fl_nocapture", {61'b0, ds_to_es_valid, ds_stall, ds_allowin}, 64'd1);
        wb_valid = 1'b1; wb_addr = 5'd9;
        tick(); tick();
        wb_valid = 1'b0;
        fs_set(1'b1, 5'd0, 1'b0, 5'd9, 5'd0, 2'b01, 64'h8888);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("fl_pend_kept", {63'b0, ds_stall}, 64'd1);
        wb_valid = 1'b1; wb_addr = 5'd9;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("fl_pend_clear", {62'b0, ds_stall, ds_to_es_valid}, 64'd1);
        chk("fl_rf_src", ds_src_value, 64'h0000_0000_A000_0009);
        tick();

        // r0 and unused sources always read as zero.
        fs_set(1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 2'b01, 64'hAAAA);
        tick();
        fs_to_ds_valid = 1'b0;
        fwd_set(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        fwd_set(1, 1'b1, 1'b1, 5'd5, 32'h5A5A);
        #1;
        chk("r0_src", ds_src_value, 64'h0);
        chk("r0_go", {62'b0, ds_stall, ds_to_es_valid}, 64'd1);
        tick();
        fwd_set(0, 1'b0, 1'b0, 5'd0, 32'h0);
        fwd_set(1, 1'b0, 1'b0, 5'd0, 32'h0);

        // Reset mid-operation drops the held reader and the r11 tracking.
        fs_set(1'b1, 5'd11, 1'b1, 5'd0, 5'd0, 2'b00, 64'hB000);
        tick();
        fs_set(1'b1, 5'd0, 1'b0, 5'd11, 5'd0, 2'b01, 64'hB001);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("mr_stall", {63'b0, ds_stall}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_after", {61'b0, ds_to_es_valid, ds_stall, ds_allowin}, 64'd1);
        fs_set(1'b1, 5'd0, 1'b0, 5'd11, 5'd0, 2'b01, 64'hB002);
        tick();
        fs_to_ds_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd11;
        #1;
        chk("mr_nostall", {62'b0, ds_stall, ds_to_es_valid}, 64'd1);
        chk("mr_src", ds_src_value, 64'h0000_0000_A000_000B);
        tick();
        wb_valid = 1'b0;
        fs_set(1'b1, 5'd0, 1'b0, 5'd11, 5'd0, 2'b01, 64'hB003);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("mr_wb_noop", {62'b0, ds_stall, ds_to_es_valid}, 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
